// File: rtl/ysyx_22050019_pkg.sv
// Shared constants for the MEM/WB pipeline slice.
// Source indices and parameter defaults.
package ysyx_22050019_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int RADDR_W_DEF = 5;
  localparam int NSRC_DEF    = 3;
  localparam int NCSR_DEF    = 4;

  localparam int SRC_EXU = 0;
  localparam int SRC_CSR = 1;
  localparam int SRC_LSU = 2;

endpackage

// File: rtl/ysyx_22050019_mem_wb_pipe_if.sv
// Valid/ready handshake bundle carrying a packed payload.
// master drives valid/data, slave drives ready.
interface ysyx_22050019_mem_wb_pipe_if #(
  parameter int W = 64
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/ysyx_22050019_skid_buf.sv
// Two-entry skid buffer (main + skid) with registered ready.
// Flush drops both entries; ready never depends on downstream ready.
module ysyx_22050019_skid_buf
  import ysyx_22050019_pkg::*;
#(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  ysyx_22050019_mem_wb_pipe_if.slave  s_if,
  ysyx_22050019_mem_wb_pipe_if.master m_if
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc, pop;

  assign acc = s_if.valid && rdy_q && !flush;
  assign pop = main_v_q && m_if.ready;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (pop) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (acc) begin
      if (!main_v_q || pop) begin
        main_v_d = 1'b1;
        main_d   = s_if.data;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = s_if.data;
      end
    end else if (pop) begin
      main_v_d = 1'b0;
    end
    rdy_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign s_if.ready = rdy_q;
  assign m_if.valid = main_v_q;
  assign m_if.data  = main_q;

endmodule

// File: rtl/ysyx_22050019_mem_wb_pipe.sv
// MEM->WB pipeline register: priority source select, skid
// buffering, retire counter and multi-enable error flag.
module ysyx_22050019_mem_wb_pipe
  import ysyx_22050019_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int NSRC    = NSRC_DEF,
  parameter int NCSR    = NCSR_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [NSRC-1:0]         src_we,
  input  logic [NSRC*RADDR_W-1:0] src_waddr,
  input  logic [NSRC*XLEN-1:0]    src_wdata,
  input  logic [NCSR*XLEN-1:0]    csr_diff_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic                    wb_we,
  output logic [RADDR_W-1:0]      wb_waddr,
  output logic [XLEN-1:0]         wb_wdata,
  output logic [NCSR*XLEN-1:0]    csr_diff_o,
  output logic [63:0]             retire_cnt,
  output logic                    multi_we_err
);

  localparam int CW = NCSR * XLEN;
  localparam int PW = CW + XLEN + 1 + RADDR_W + XLEN;

  logic               sel_we;
  logic [RADDR_W-1:0] sel_waddr;
  logic [XLEN-1:0]    sel_wdata;
  logic               st_we;
  logic               acc, fire, multi;
  logic [63:0]        retire_cnt_q;
  logic               multi_q;

  ysyx_22050019_mem_wb_pipe_if #(.W(PW)) up_if ();
  ysyx_22050019_mem_wb_pipe_if #(.W(PW)) dn_if ();

  // Walk high-to-low so the lowest enabled index wins.
  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_we[i]) begin
        sel_waddr = src_waddr[i*RADDR_W +: RADDR_W];
        sel_wdata = src_wdata[i*XLEN +: XLEN];
      end
    end
    sel_we = (|src_we) && (sel_waddr != '0);
  end

  assign multi = |(src_we & (src_we - NSRC'(1)));

  assign up_if.valid = in_valid;
  assign up_if.data  = {csr_diff_i, in_pc, sel_we,
                        sel_waddr, sel_wdata};
  assign in_ready    = up_if.ready;

  ysyx_22050019_skid_buf #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .s_if  (up_if),
    .m_if  (dn_if)
  );

  assign out_valid   = dn_if.valid;
  assign dn_if.ready = out_ready;
  assign {csr_diff_o, out_pc, st_we,
          wb_waddr, wb_wdata} = dn_if.data;
  assign wb_we = out_valid && st_we;

  assign acc  = in_valid && in_ready && !flush;
  assign fire = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
      multi_q      <= 1'b0;
    end else begin
      if (fire) retire_cnt_q <= retire_cnt_q + 64'd1;
      if (acc && multi) multi_q <= 1'b1;
    end
  end

  assign retire_cnt   = retire_cnt_q;
  assign multi_we_err = multi_q;

endmodule

// File: tb/tb_ysyx_22050019_mem_wb_pipe.sv
// Directed bench for the MEM/WB pipeline register.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_ysyx_22050019_mem_wb_pipe;
  import ysyx_22050019_pkg::*;

  logic         clk, rst, flush;
  logic [2:0]   src_we;
  logic [14:0]  src_waddr;
  logic [191:0] src_wdata;
  logic [255:0] csr_diff_i, csr_diff_o;
  logic         wb_we, multi_we_err;
  logic [4:0]   wb_waddr;
  logic [63:0]  wb_wdata, retire_cnt;
  int n_chk = 0;
  int n_pass = 0;

  ysyx_22050019_mem_wb_pipe_if #(.W(64)) in_bus ();
  ysyx_22050019_mem_wb_pipe_if #(.W(64)) out_bus ();

  ysyx_22050019_mem_wb_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_bus.valid),
    .in_ready     (in_bus.ready),
    .in_pc        (in_bus.data),
    .src_we       (src_we),
    .src_waddr    (src_waddr),
    .src_wdata    (src_wdata),
    .csr_diff_i   (csr_diff_i),
    .out_valid    (out_bus.valid),
    .out_ready    (out_bus.ready),
    .out_pc       (out_bus.data),
    .wb_we        (wb_we),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .csr_diff_o   (csr_diff_o),
    .retire_cnt   (retire_cnt),
    .multi_we_err (multi_we_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_src();
    src_we    = '0;
    src_waddr = '0;
    src_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_chk++; if (out_bus.valid !== 1'b0) $display("FAIL rst_out_valid: got %0h want 0", out_bus.valid); else n_pass++;
    n_chk++; if (in_bus.ready !== 1'b0) $display("FAIL rst_in_ready: got %0h want 0", in_bus.ready); else n_pass++;
    n_chk++; if (wb_we !== 1'b0) $display("FAIL rst_wb_we: got %0h want 0", wb_we); else n_pass++;
    n_chk++; if (retire_cnt !== 64'd0) $display("FAIL rst_retire: got %0h want 0", retire_cnt); else n_pass++;
    n_chk++; if (multi_we_err !== 1'b0) $display("FAIL rst_multi: got %0h want 0", multi_we_err); else n_pass++;
    rst = 1'b0;
    step();
    n_chk++; if (in_bus.ready !== 1'b1) $display("FAIL rst_release_ready: got %0h want 1", in_bus.ready); else n_pass++;
  endtask

  task automatic test_lsu();
    out_bus.ready = 1'b1;
    in_bus.valid  = 1'b1;
    in_bus.data   = 64'h1000;
    clr_src();
    src_we = 3'b100;
    src_waddr[SRC_LSU*5 +: 5]  = 5'd7;
    src_wdata[SRC_LSU*64 +: 64] = 64'hDEAD;
    src_waddr[SRC_EXU*5 +: 5]  = 5'd5;
    src_wdata[SRC_EXU*64 +: 64] = 64'hBEEF;
    csr_diff_i = {64'h4, 64'h3, 64'h2, 64'h1};
    step();
    in_bus.valid = 1'b0;
    n_chk++; if (out_bus.valid !== 1'b1) $display("FAIL lsu_valid: got %0h want 1", out_bus.valid); else n_pass++;
    n_chk++; if (wb_we !== 1'b1) $display("FAIL lsu_we: got %0h want 1", wb_we); else n_pass++;
    n_chk++; if (wb_waddr !== 5'd7) $display("FAIL lsu_waddr: got %0h want 7", wb_waddr); else n_pass++;
    n_chk++; if (wb_wdata !== 64'hDEAD) $display("FAIL lsu_wdata: got %0h want dead", wb_wdata); else n_pass++;
    n_chk++; if (out_bus.data !== 64'h1000) $display("FAIL lsu_pc: got %0h want 1000", out_bus.data); else n_pass++;
    n_chk++; if (csr_diff_o !== {64'h4, 64'h3, 64'h2, 64'h1}) $display("FAIL lsu_csr: got %0h want 4_3_2_1", csr_diff_o); else n_pass++;
    n_chk++; if (retire_cnt !== 64'd0) $display("FAIL lsu_retire0: got %0h want 0", retire_cnt); else n_pass++;
    n_chk++; if (multi_we_err !== 1'b0) $display("FAIL lsu_multi: got %0h want 0", multi_we_err); else n_pass++;
    step();
    n_chk++; if (retire_cnt !== 64'd1) $display("FAIL lsu_retire1: got %0h want 1", retire_cnt); else n_pass++;
    n_chk++; if (out_bus.valid !== 1'b0) $display("FAIL lsu_drained: got %0h want 0", out_bus.valid); else n_pass++;
  endtask

  task automatic test_priority();
    in_bus.valid = 1'b1;
    in_bus.data  = 64'h2000;
    clr_src();
    src_we = 3'b011;
    src_waddr = {5'd9, 5'd4, 5'd3};
    src_wdata = {64'h33, 64'h22, 64'h11};
    step();
    in_bus.valid = 1'b0;
    n_chk++; if (wb_waddr !== 5'd3) $display("FAIL prio_waddr: got %0h want 3", wb_waddr); else n_pass++;
    n_chk++; if (wb_wdata !== 64'h11) $display("FAIL prio_wdata: got %0h want 11", wb_wdata); else n_pass++;
    n_chk++; if (wb_we !== 1'b1) $display("FAIL prio_we: got %0h want 1", wb_we); else n_pass++;
    n_chk++; if (multi_we_err !== 1'b1) $display("FAIL prio_multi: got %0h want 1", multi_we_err); else n_pass++;
    repeat (10) step();
    n_chk++; if (multi_we_err !== 1'b1) $display("FAIL prio_multi_sticky: got %0h want 1", multi_we_err); else n_pass++;
    n_chk++; if (retire_cnt !== 64'd2) $display("FAIL prio_retire: got %0h want 2", retire_cnt); else n_pass++;
  endtask

  task automatic test_zero_addr();
    in_bus.valid = 1'b1;
    in_bus.data  = 64'h3000;
    clr_src();
    src_we = 3'b001;
    src_wdata[SRC_EXU*64 +: 64] = 64'h55;
    step();
    in_bus.valid = 1'b0;
    n_chk++; if (out_bus.valid !== 1'b1) $display("FAIL x0_valid: got %0h want 1", out_bus.valid); else n_pass++;
    n_chk++; if (wb_we !== 1'b0) $display("FAIL x0_we: got %0h want 0", wb_we); else n_pass++;
    step();
    n_chk++; if (retire_cnt !== 64'd3) $display("FAIL x0_retire: got %0h want 3", retire_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clr_src();
    out_bus.ready = 1'b0;
    in_bus.valid  = 1'b1;
    in_bus.data   = 64'h8000_0000;
    step();
    n_chk++; if (in_bus.ready !== 1'b1) $display("FAIL b2b_ready1: got %0h want 1", in_bus.ready); else n_pass++;
    in_bus.data = 64'h8000_0004;
    step();
    n_chk++; if (in_bus.ready !== 1'b0) $display("FAIL b2b_ready2: got %0h want 0", in_bus.ready); else n_pass++;
    in_bus.data = 64'h8000_0008;
    step();
    n_chk++; if (in_bus.ready !== 1'b0) $display("FAIL b2b_ready3: got %0h want 0", in_bus.ready); else n_pass++;
    n_chk++; if (out_bus.data !== 64'h8000_0000) $display("FAIL b2b_pc0: got %0h want 80000000", out_bus.data); else n_pass++;
    n_chk++; if (wb_we !== 1'b0) $display("FAIL b2b_nowe: got %0h want 0", wb_we); else n_pass++;
    out_bus.ready = 1'b1;
    step();
    n_chk++; if (out_bus.data !== 64'h8000_0004) $display("FAIL b2b_pc1: got %0h want 80000004", out_bus.data); else n_pass++;
    n_chk++; if (out_bus.valid !== 1'b1) $display("FAIL b2b_valid1: got %0h want 1", out_bus.valid); else n_pass++;
    step();
    in_bus.valid = 1'b0;
    n_chk++; if (out_bus.data !== 64'h8000_0008) $display("FAIL b2b_pc2: got %0h want 80000008", out_bus.data); else n_pass++;
    n_chk++; if (out_bus.valid !== 1'b1) $display("FAIL b2b_valid2: got %0h want 1", out_bus.valid); else n_pass++;
    step();
    n_chk++; if (out_bus.valid !== 1'b0) $display("FAIL b2b_empty: got %0h want 0", out_bus.valid); else n_pass++;
    n_chk++; if (retire_cnt !== 64'd6) $display("FAIL b2b_retire: got %0h want 6", retire_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    out_bus.ready = 1'b0;
    in_bus.valid  = 1'b1;
    in_bus.data   = 64'hA0;
    step();
    in_bus.data = 64'hA4;
    step();
    n_chk++; if (in_bus.ready !== 1'b0) $display("FAIL fl_full: got %0h want 0", in_bus.ready); else n_pass++;
    flush = 1'b1;
    in_bus.data = 64'hA8;
    out_bus.ready = 1'b1;
    step();
    flush = 1'b0;
    in_bus.valid = 1'b0;
    n_chk++; if (out_bus.valid !== 1'b0) $display("FAIL fl_valid: got %0h want 0", out_bus.valid); else n_pass++;
    n_chk++; if (in_bus.ready !== 1'b1) $display("FAIL fl_ready: got %0h want 1", in_bus.ready); else n_pass++;
    n_chk++; if (retire_cnt !== 64'd6) $display("FAIL fl_retire: got %0h want 6", retire_cnt); else n_pass++;
    step();
    n_chk++; if (out_bus.valid !== 1'b0) $display("FAIL fl_dropped: got %0h want 0", out_bus.valid); else n_pass++;
  endtask

  task automatic test_wrap();
    out_bus.ready = 1'b1;
    in_bus.valid  = 1'b1;
    in_bus.data   = 64'hC0;
    step();
    in_bus.valid = 1'b0;
    force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    step();
    n_chk++; if (retire_cnt !== 64'd0) $display("FAIL wrap_retire: got %0h want 0", retire_cnt); else n_pass++;
  endtask

  task automatic test_rst_mid_stall();
    out_bus.ready = 1'b1;
    in_bus.valid  = 1'b1;
    in_bus.data   = 64'hD0;
    clr_src();
    src_we = 3'b100;
    src_waddr[SRC_LSU*5 +: 5]  = 5'd7;
    src_wdata[SRC_LSU*64 +: 64] = 64'hDEAD;
    step();
    in_bus.data = 64'hD4;
    step();
    out_bus.ready = 1'b0;
    in_bus.data = 64'hD8;
    step();
    n_chk++; if (retire_cnt !== 64'd1) $display("FAIL rs_pre_retire: got %0h want 1", retire_cnt); else n_pass++;
    n_chk++; if (wb_we !== 1'b1) $display("FAIL rs_pre_we: got %0h want 1", wb_we); else n_pass++;
    rst = 1'b1;
    step();
    n_chk++; if (out_bus.valid !== 1'b0) $display("FAIL rs_valid: got %0h want 0", out_bus.valid); else n_pass++;
    n_chk++; if (in_bus.ready !== 1'b0) $display("FAIL rs_ready: got %0h want 0", in_bus.ready); else n_pass++;
    n_chk++; if (out_bus.data !== 64'd0) $display("FAIL rs_pc: got %0h want 0", out_bus.data); else n_pass++;
    n_chk++; if (wb_we !== 1'b0) $display("FAIL rs_we: got %0h want 0", wb_we); else n_pass++;
    n_chk++; if (wb_waddr !== 5'd0) $display("FAIL rs_waddr: got %0h want 0", wb_waddr); else n_pass++;
    n_chk++; if (wb_wdata !== 64'd0) $display("FAIL rs_wdata: got %0h want 0", wb_wdata); else n_pass++;
    n_chk++; if (csr_diff_o !== 256'd0) $display("FAIL rs_csr: got %0h want 0", csr_diff_o); else n_pass++;
    n_chk++; if (retire_cnt !== 64'd0) $display("FAIL rs_retire: got %0h want 0", retire_cnt); else n_pass++;
    n_chk++; if (multi_we_err !== 1'b0) $display("FAIL rs_multi: got %0h want 0", multi_we_err); else n_pass++;
    rst = 1'b0;
    in_bus.valid = 1'b0;
    step();
    n_chk++; if (in_bus.ready !== 1'b1) $display("FAIL rs_release_ready: got %0h want 1", in_bus.ready); else n_pass++;
    n_chk++; if (out_bus.valid !== 1'b0) $display("FAIL rs_release_valid: got %0h want 0", out_bus.valid); else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    in_bus.valid  = 1'b0;
    in_bus.data   = '0;
    out_bus.ready = 1'b0;
    csr_diff_i    = '0;
    clr_src();
    @(negedge clk);
    test_reset();
    test_lsu();
    test_priority();
    test_zero_addr();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_rst_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_mem_wb_pipe.md
YSYX_22050019_MEM_WB_PIPE -- requirements
Module: ysyx_22050019_mem_wb_pipe

Interface
REQ-001 SHALL have parameters: XLEN, default 64, datapath width; RADDR_W, default 5, register address width; NSRC, default 3, number of writeback sources (index 0 = EXU, 1 = CSR, 2 = LSU); NCSR, default 4, number of difftest CSR mirrors.
REQ-002 SHALL have these ports, in order:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  MEM entry offered
- in_ready  out  1  stage can accept an entry
- in_pc  in  XLEN  PC of the entry
- src_we  in  NSRC  per-source write enable
- src_waddr  in  NSRC*RADDR_W  per-source destination; source i occupies bits [i*RADDR_W +: RADDR_W]
- src_wdata  in  NSRC*XLEN  per-source write data, packed the same way
- csr_diff_i  in  NCSR*XLEN  CSR snapshot for difftest
- out_valid  out  1  WB entry present
- out_ready  in  1  WB/regfile consumes the entry
- out_pc  out  XLEN  retired PC
- wb_we, wb_waddr, wb_wdata  out  1 / RADDR_W / XLEN  regfile write port
- csr_diff_o  out  NCSR*XLEN  CSR snapshot aligned with out_pc
- retire_cnt  out  64  retired-instruction counter
- multi_we_err  out  1  sticky flag: more than one source enabled

Function
REQ-003 SHALL accept an entry on an edge where in_valid && in_ready && !flush.
REQ-004 SHALL resolve sources at acceptance by fixed priority, lowest index with src_we set; it SHALL NOT OR-merge addresses or data.
REQ-005 SHALL store we = |src_we && sel_waddr != 0; waddr and wdata come from the selected source. With no source enabled: we = 0, waddr = 0, wdata = 0.
REQ-006 SHALL capture in_pc and csr_diff_i unchanged with the entry.
REQ-007 SHALL implement a two-entry skid buffer (main plus skid). Latency from acceptance to out_valid is exactly 1 cycle; full throughput of 1 entry/cycle when out_ready is held high.
REQ-008 SHALL drive in_ready = !skid_valid, taken from a register only (no combinational path from out_ready).
REQ-009 SHALL move an accepted entry into skid when main holds an entry and out_ready = 0 that cycle; skid drains to main when main is consumed.
REQ-010 SHALL preserve entry order (FIFO).
REQ-011 SHALL complete a transfer when out_valid && out_ready; outputs SHALL be stable while out_valid && !out_ready.
REQ-012 SHALL, on flush: invalidate main and skid at the edge, drop any entry offered that cycle, assert in_ready the following cycle, and not count a retire that cycle.
REQ-013 SHALL increment retire_cnt by 1 per completed transfer, wrapping 2^64-1 -> 0.
REQ-014 SHALL set multi_we_err when an accepted entry has popcount(src_we) > 1; it clears only on rst.
REQ-015 SHALL drive wb_we = out_valid && stored we.

Reset
REQ-016 SHALL, while rst = 1: main and skid invalid; out_valid 0; in_ready 0; out_pc, wb_waddr, wb_wdata, csr_diff_o, retire_cnt all 0; wb_we 0; multi_we_err 0.
REQ-017 SHALL deassert in_ready during the rst cycle and reassert it the first cycle after rst falls.
REQ-018 SHALL give rst priority over flush and over any handshake.

Structure
REQ-019 SHALL place source index constants (SRC_EXU, SRC_CSR, SRC_LSU) and parameter defaults in the shared package ysyx_22050019_pkg.
REQ-020 SHALL realise the skid buffer as sub-module ysyx_22050019_skid_buf, parametrised by payload width; the priority select and retire counter stay in the top level.

Verification
REQ-021 SHALL cover: src_we = 3'b100, LSU waddr 7, wdata 0xDEAD, out_ready = 1 -> next cycle wb_we = 1, wb_waddr = 7, wb_wdata = 0xDEAD, retire_cnt 0 -> 1.
REQ-022 SHALL cover: src_we = 3'b011 (EXU waddr 3, data 0x11; CSR waddr 4, data 0x22) -> wb_waddr = 3, wb_wdata = 0x11, multi_we_err = 1, still 1 after 10 cycles.
REQ-023 SHALL cover: EXU waddr 0 with src_we = 3'b001 -> out_valid = 1, wb_we = 0, retire_cnt increments.
REQ-024 SHALL cover: out_ready = 0 with 3 back-to-back entries (PC 0x80000000, 0x80000004, 0x80000008) -> in_ready falls after the 2nd; releasing out_ready yields all three PCs in order on consecutive cycles.
REQ-025 SHALL cover: two entries buffered then flush = 1 while in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, retire_cnt unchanged.
REQ-026 SHALL cover: retire_cnt forced to 0xFFFF_FFFF_FFFF_FFFF, one transfer -> 0; and rst asserted mid-stall -> every output takes its REQ-016 reset value.
